// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS               = 8;
  localparam int unsigned UART_DEFAULT_CLOCKS_PER_BAUD = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a separate occupancy counter.
// Read data is the current head entry, so it is valid whenever the FIFO is not empty.
module uart_sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == FULL_COUNT);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally; occupancy tracks push/pop, unchanged when both occur.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready byte input into a FIFO, serialised
// LSB first as 8N1 frames. Defining UART_TX_PARITY_EN adds an even-parity
// bit between data and stop (8E1).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned TIMER_BITS      = 10,
  parameter int unsigned CLOCKS_PER_BAUD = UART_DEFAULT_CLOCKS_PER_BAUD,
  parameter int unsigned FIFO_DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          i_reset,
  input  logic [7:0]                    i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_drop,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_busy,
  output logic                          o_tx
);

  localparam logic [TIMER_BITS-1:0] BAUD_RELOAD = TIMER_BITS'(CLOCKS_PER_BAUD - 1);
  localparam logic [2:0]            LAST_BIT    = 3'(UART_DATA_BITS - 1);

  uart_state_e               state, state_n;
  logic [TIMER_BITS-1:0]     baud_cnt, baud_cnt_n;
  logic [UART_DATA_BITS-1:0] shreg, shreg_n;
  logic [2:0]                bit_idx, bit_idx_n;
  logic                      tx_q, tx_n;
  logic                      baud_tick;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic [UART_DATA_BITS-1:0] fifo_rdata;
  logic                      fifo_full;
  logic                      fifo_empty;

`ifdef UART_TX_PARITY_EN
  logic                      par_q, par_n;
`endif

  assign o_ready   = !fifo_full;
  assign o_drop    = i_valid && fifo_full;
  assign fifo_push = i_valid && !fifo_full;
  assign o_busy    = (state != IDLE) || !fifo_empty;
  assign o_tx      = tx_q;
  assign baud_tick = (baud_cnt == '0);

  uart_sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_reset (i_reset),
    .push    (fifo_push),
    .wdata   (i_data),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (o_count)
  );

  // Next-state, baud timing, shift register and FIFO pop; the line level is
  // derived from the next state so o_tx comes straight from a flop.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    shreg_n    = shreg;
    bit_idx_n  = bit_idx;
    fifo_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n      = par_q;
`endif

    if (state != IDLE) begin
      baud_cnt_n = baud_tick ? BAUD_RELOAD : baud_cnt - 1'b1;
    end

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shreg_n    = fifo_rdata;
          baud_cnt_n = BAUD_RELOAD;
          state_n    = START;
`ifdef UART_TX_PARITY_EN
          par_n      = ^fifo_rdata;
`endif
        end
      end
      START: begin
        if (baud_tick) begin
          state_n   = DATA;
          bit_idx_n = '0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            shreg_n   = shreg >> 1;
            bit_idx_n = bit_idx + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        // Chain straight into the next start bit when more data is queued.
        if (baud_tick) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_n  = fifo_rdata;
            state_n  = START;
`ifdef UART_TX_PARITY_EN
            par_n    = ^fifo_rdata;
`endif
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_n = par_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

  // State, datapath and line registers.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      shreg    <= '0;
      bit_idx  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      shreg    <= shreg_n;
      bit_idx  <= bit_idx_n;
      tx_q     <= tx_n;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (CLOCKS_PER_BAUD = 4, FIFO_DEPTH = 4).
// Honours UART_TX_PARITY_EN for the expected frame shape.
module tb_uart_tx_fifo;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam int unsigned FCLK = NBITS * CPB;

  logic       clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       o_drop;
  logic [2:0] o_count;
  logic       o_busy;
  logic       o_tx;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .TIMER_BITS      (10),
    .CLOCKS_PER_BAUD (CPB),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk     (clk),
    .i_reset (i_reset),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_drop  (o_drop),
    .o_count (o_count),
    .o_busy  (o_busy),
    .o_tx    (o_tx)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level for frame bit idx: start, 8 data LSB first, [parity], stop.
  function automatic logic frame_bit(input logic [7:0] b, input int unsigned idx);
    logic [7:0] v;
    v = b;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return v[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^v;
`endif
    return 1'b1;
  endfunction

  // Check line clocks k0..k1-1 of a frame; on entry the sample is clock k0.
  task automatic check_frame(input logic [7:0] b, input int unsigned k0, input int unsigned k1);
    for (int unsigned k = k0; k < k1; k++) begin
      check_eq($sformatf("tx_%02h_k%0d", b, k), {31'b0, o_tx}, {31'b0, frame_bit(b, k / CPB)});
      tick();
    end
  endtask

  task automatic send_single(input logic [7:0] b);
    i_data  = b;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    check_eq("single_count_after_push", o_count, 1);
    check_eq("single_tx_idle_after_push", o_tx, 1);
    check_eq("single_busy_after_push", o_busy, 1);
    tick();
    check_eq("single_count_after_pop", o_count, 0);
    check_frame(b, 0, FCLK);
    check_eq("single_busy_after_frame", o_busy, 0);
    check_eq("single_tx_after_frame", o_tx, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  fb [6];
    int unsigned ecnt [6];
    fb   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    ecnt = '{1, 1, 2, 3, 4, 4};

    i_reset = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    tick();
    tick();
    i_reset = 1'b0;
    check_eq("reset_tx", o_tx, 1);
    check_eq("reset_ready", o_ready, 1);
    check_eq("reset_drop", o_drop, 0);
    check_eq("reset_count", o_count, 0);
    check_eq("reset_busy", o_busy, 0);

    // Single frames; 0x07 / 0x03 exercise both parity values in the 8E1 build.
    send_single(8'h55);
    send_single(8'h07);
    send_single(8'h03);

    // Back-to-back: second start bit immediately follows first stop bit.
    i_data  = 8'hA5;
    i_valid = 1'b1;
    tick();
    i_data  = 8'h3C;
    tick();
    i_valid = 1'b0;
    check_eq("b2b_count", o_count, 1);
    check_frame(8'hA5, 0, FCLK);
    check_frame(8'h3C, 0, FCLK);
    check_eq("b2b_busy_end", o_busy, 0);
    check_eq("b2b_count_end", o_count, 0);

    // Fill: 6 pushes on consecutive cycles, first byte popped on the 2nd edge.
    for (int i = 0; i < 6; i++) begin
      i_data  = fb[i];
      i_valid = 1'b1;
      #1;
      check_eq($sformatf("fill_ready_%0d", i), o_ready, (i < 5) ? 1 : 0);
      check_eq($sformatf("fill_drop_%0d", i), o_drop, (i == 5) ? 1 : 0);
      tick();
      check_eq($sformatf("fill_count_%0d", i), o_count, ecnt[i]);
    end
    i_valid = 1'b0;
    #1;
    check_eq("fill_drop_idle", o_drop, 0);
    check_frame(8'h11, 4, FCLK - 1);

    // Push while full on the same edge as the pop: rejected.
    check_eq("fullpop_tx_stop", o_tx, 1);
    i_data  = 8'h77;
    i_valid = 1'b1;
    #1;
    check_eq("fullpop_drop", o_drop, 1);
    check_eq("fullpop_ready", o_ready, 0);
    check_eq("fullpop_count", o_count, 4);
    tick();
    i_valid = 1'b0;
    check_eq("fullpop_ready_next", o_ready, 1);
    check_eq("fullpop_count_next", o_count, 3);
    check_frame(8'h22, 0, FCLK);
    check_frame(8'h33, 0, FCLK);
    check_frame(8'h44, 0, FCLK);
    check_frame(8'h55, 0, FCLK);
    check_eq("fill_busy_end", o_busy, 0);
    check_eq("fill_count_end", o_count, 0);

    // Reset during data bit 3 of 0x00 with another byte queued.
    i_data  = 8'h00;
    i_valid = 1'b1;
    tick();
    i_data  = 8'h5A;
    tick();
    i_valid = 1'b0;
    check_eq("rst_count_queued", o_count, 1);
    check_frame(8'h00, 0, 17);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check_eq("rst_tx", o_tx, 1);
    check_eq("rst_count", o_count, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_ready", o_ready, 1);
    for (int i = 0; i < 50; i++) begin
      tick();
      check_eq($sformatf("rst_line_idle_%0d", i), o_tx, 1);
    end
    check_eq("rst_busy_end", o_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
